reg_file_mp: RTL



---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/reg_file_mp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   rf_state_e : sequencer states (CLEAR sweep after reset, RUN)
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   ZERO_REG   : index of the hardwired-zero register
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_RUN   = RUN;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
//   clk        : clock
//   sweep_en/sweep_idx : clear one busy bit per cycle during the reset sweep
//   set_en/set_idx     : mark a destination busy at issue
//   clr_en/clr_idx     : writeback releases the destination
//   look_addr  : NRD lookup addresses
//   look_busy  : busy bit of each lookup address (0 for x0 / out of range)
// Enables are qualified by the caller; set beats clear on the same index.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    sweep_en,
    input  logic [AW-1:0]           sweep_idx,
    input  logic                    set_en,
    input  logic [AW-1:0]           set_idx,
    input  logic                    clr_en,
    input  logic [AW-1:0]           clr_idx,
    input  logic [NRD-1:0][AW-1:0]  look_addr,
    output logic [NRD-1:0]          look_busy
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [NREGS-1:0] busy_q;

    always_ff @(posedge clk) begin
        busy_q[0] <= 1'b0;
        for (int j = 1; j < NREGS; j++) begin
            if (sweep_en && sweep_idx == AW'(j)) begin
                busy_q[j] <= 1'b0;
            end else if (set_en && set_idx == AW'(j)) begin
                busy_q[j] <= 1'b1;
            end else if (clr_en && clr_idx == AW'(j)) begin
                busy_q[j] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            look_busy[i] = 1'b0;
            if ({1'b0, look_addr[i]} < NREGS_W) begin
                look_busy[i] = busy_q[look_addr[i]];
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with x0 hardwired to zero, optional
// write-to-read bypass, busy scoreboard and a post-reset clear sweep.
//   clk, rst            : clock, synchronous active-high reset
//   rd_addr / rd_data   : NRD combinational read ports
//   rd_busy             : scoreboard busy bit per read port
//   we/wr_addr/wr_data  : writeback port (also releases busy)
//   mark_en/mark_addr   : mark destination busy at issue
//   ready               : clear sweep finished
//   dbg_q               : stored value of register DBG_IDX (no bypass)
//
// state | meaning
// CLEAR | zero entry cnt and its busy bit each cycle; outputs forced to 0
// RUN   | normal operation, ready=1
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int DBG_IDX = 10,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     we,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     mark_en,
    input  logic [AW-1:0]            mark_addr,
    output logic                     ready,
    output logic [XLEN-1:0]          dbg_q
);

    localparam logic [AW-1:0] LAST    = AW'(NREGS-1);
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] X0      = AW'(ZERO_REG);

    logic [0:0]      state_q;
    logic [AW-1:0]   cnt_q;
    logic [XLEN-1:0] mem [NREGS];
    logic            run;
    logic            clearing;
    logic            wr_ok;
    logic            mark_ok;
    logic [NRD-1:0]  sb_busy;

    // Writable/readable: not x0 and inside the implemented range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != X0) && ({1'b0, a} < NREGS_W);
    endfunction

    assign run      = (state_q == ST_RUN);
    assign clearing = (state_q == ST_CLEAR) && !rst;
    assign wr_ok    = run && !rst && we && addr_ok(wr_addr);
    assign mark_ok  = run && !rst && mark_en && addr_ok(mark_addr);
    assign ready    = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == LAST) begin
                state_q <= ST_RUN;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .sweep_en  (clearing),
        .sweep_idx (cnt_q),
        .set_en    (mark_ok),
        .set_idx   (mark_addr),
        .clr_en    (wr_ok),
        .clr_idx   (wr_addr),
        .look_addr (rd_addr),
        .look_busy (sb_busy)
    );

    // A forwarded write also reports not-busy: the value is already here.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
            if (run && addr_ok(rd_addr[i])) begin
                if (BYPASS != 0 && we && wr_addr == rd_addr[i]) begin
                    rd_data[i] = wr_data;
                end else begin
                    rd_data[i] = mem[rd_addr[i]];
                    rd_busy[i] = sb_busy[i];
                end
            end
        end
    end

    generate
        if (DBG_IDX > 0 && DBG_IDX < NREGS) begin : g_dbg
            assign dbg_q = run ? mem[DBG_IDX] : '0;
        end else begin : g_dbg_zero
            assign dbg_q = '0;
        end
    endgenerate

endmodule
